// File: rtl/rtc_pkg.sv
// Shared constants and type encodings for the rtc adjustment front-end.
package rtc_pkg;

   localparam logic [31:0] NS_PER_SEC = 32'd1000000000;

   typedef enum logic [1:0] {
      CMD_SET_TIME = 2'd0,
      CMD_STEP     = 2'd1,
      CMD_SET_INC  = 2'd2,
      CMD_RSVD     = 2'd3
   } cmd_type_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_GAP,
      ST_CALC,
      ST_NORM,
      ST_APPLY,
      ST_SETTLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/rtc_adj_ctrl_if.sv
// Command handshake bundle between a host/servo and rtc_adj_ctrl.
interface rtc_adj_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic        cmd_sign;
   logic [29:0] cmd_nanosec;
   logic [31:0] cmd_sec;
   logic [15:0] cmd_epoch;
   logic [25:0] cmd_increment;
   logic        cmd_err;

   modport master (
      output cmd_valid, cmd_type, cmd_sign, cmd_nanosec, cmd_sec, cmd_epoch, cmd_increment,
      input  cmd_ready, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_sign, cmd_nanosec, cmd_sec, cmd_epoch, cmd_increment,
      output cmd_ready, cmd_err
   );
endinterface

// File: rtl/rtc_offset_norm.sv
// Offset accumulator: stage 1 forms the raw ns sum/difference, stage 2
// folds it back into 0..1e9-1 and propagates the carry into 48-bit seconds.
module rtc_offset_norm
   import rtc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        calc_en,
   input  logic        norm_en,
   input  logic        clr,
   input  logic        sub,
   input  logic [29:0] d_ns,
   input  logic [47:0] d_sec,
   output logic [29:0] off_ns,
   output logic [47:0] off_sec
);

   localparam logic signed [31:0] NS_S = $signed(NS_PER_SEC);

   logic signed [31:0] s_calc;
   logic signed [31:0] s_q;
   logic               sub_q;
   logic [29:0]        ns_norm;
   logic [47:0]        carry;
   logic [47:0]        sec_next;

   // Raw ns result; both operands are below 1e9 so 32-bit signed cannot overflow.
   always_comb begin
      s_calc = $signed({2'b00, off_ns}) + $signed({2'b00, d_ns});
      if (sub) s_calc = $signed({2'b00, off_ns}) - $signed({2'b00, d_ns});
   end

   // Stage 1 register: raw ns result and the direction it was produced with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q   <= '0;
         sub_q <= 1'b0;
      end else if (calc_en) begin
         s_q   <= s_calc;
         sub_q <= sub;
      end
   end

   // Normalise ns into range and derive the +1/0/-1 seconds carry.
   always_comb begin
      ns_norm = s_q[29:0];
      carry   = '0;
      if (s_q >= NS_S) begin
         ns_norm = 30'(s_q - NS_S);
         carry   = 48'd1;
      end else if (s_q < 32'sd0) begin
         ns_norm = 30'(s_q + NS_S);
         carry   = '1;
      end
      sec_next = sub_q ? (off_sec - d_sec + carry) : (off_sec + d_sec + carry);
   end

   // Stage 2 register is the accumulated offset itself; clr wins over update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_ns  <= '0;
         off_sec <= '0;
      end else if (clr) begin
         off_ns  <= '0;
         off_sec <= '0;
      end else if (norm_en) begin
         off_ns  <= ns_norm;
         off_sec <= sec_next;
      end
   end

endmodule

// File: rtl/rtc_adj_ctrl.sv
// Command front-end for the rtc: validates host/servo commands, keeps the
// normalised sync offset and sequences the gptp_vaild/gptp_sw strobes.
module rtc_adj_ctrl
   import rtc_pkg::*;
#(
   parameter logic [25:0] C_INC_RESET     = 26'h0800000,
   parameter int          C_SETTLE_CYCLES = 3
) (
   input  logic         rtc_clk,
   input  logic         rtc_reset,
   rtc_adj_ctrl_if.slave cmd,
   output logic [31:0]  syntonised_nanosec_field_r,
   output logic [31:0]  syntonised_sec_field_r,
   output logic [15:0]  syntonised_epoch_field_r,
   output logic [29:0]  nanosec_offset,
   output logic [31:0]  sec_offset,
   output logic [15:0]  epoch_offset,
   output logic [25:0]  rtc_increment,
   output logic         gptp_vaild,
   output logic         gptp_sw
);

   localparam logic [3:0] SETTLE_LAST = 4'(C_SETTLE_CYCLES - 1);

   state_t      state, nxt;
   logic [3:0]  settle_cnt;
   logic        accept, bad, good;
   logic        err_q;
   logic        cap_sub;
   logic [29:0] cap_ns;
   logic [47:0] cap_sec;
   logic [47:0] off_sec;

   assign accept = cmd.cmd_valid && (state == ST_IDLE);
   assign bad    = (cmd.cmd_type == CMD_RSVD) ||
                   ((cmd.cmd_type != CMD_SET_INC) && ({2'b00, cmd.cmd_nanosec} >= NS_PER_SEC)) ||
                   ((cmd.cmd_type == CMD_SET_INC) && (cmd.cmd_increment == '0));
   assign good   = accept && !bad;

   assign cmd.cmd_ready = (state == ST_IDLE);
   assign cmd.cmd_err   = err_q;
   assign gptp_vaild    = (state == ST_LOAD) || (state == ST_APPLY);
   assign gptp_sw       = (state != ST_LOAD);
   assign {epoch_offset, sec_offset} = off_sec;

   // State register and settle counter (counter runs only while settling).
   always_ff @(posedge rtc_clk or negedge rtc_reset) begin
      if (!rtc_reset) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
      end else begin
         state      <= nxt;
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
      end
   end

   // Next-state sequencing for the three command flows.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: begin
            if (good) begin
               case (cmd.cmd_type)
                  CMD_SET_TIME: nxt = ST_LOAD;
                  CMD_STEP:     nxt = ST_CALC;
                  CMD_SET_INC:  nxt = ST_DONE;
                  default:      nxt = ST_IDLE;
               endcase
            end
         end
         ST_LOAD:   nxt = ST_GAP;
         ST_GAP:    nxt = ST_APPLY;
         ST_CALC:   nxt = ST_NORM;
         ST_NORM:   nxt = ST_APPLY;
         ST_APPLY:  nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SETTLE_LAST) nxt = ST_IDLE;
         ST_DONE:   nxt = ST_IDLE;
         default:   nxt = ST_IDLE;
      endcase
   end

   // Reject pulse, one cycle after the offending handshake.
   always_ff @(posedge rtc_clk or negedge rtc_reset) begin
      if (!rtc_reset) err_q <= 1'b0;
      else            err_q <= accept && bad;
   end

   // Capture the step delta at acceptance so later input changes are ignored.
   always_ff @(posedge rtc_clk or negedge rtc_reset) begin
      if (!rtc_reset) begin
         cap_sub <= 1'b0;
         cap_ns  <= '0;
         cap_sec <= '0;
      end else if (good && (cmd.cmd_type == CMD_STEP)) begin
         cap_sub <= cmd.cmd_sign;
         cap_ns  <= cmd.cmd_nanosec;
         cap_sec <= {cmd.cmd_epoch, cmd.cmd_sec};
      end
   end

   // Base-clock load values and increment; both hold until the next write.
   always_ff @(posedge rtc_clk or negedge rtc_reset) begin
      if (!rtc_reset) begin
         syntonised_nanosec_field_r <= '0;
         syntonised_sec_field_r     <= '0;
         syntonised_epoch_field_r   <= '0;
         rtc_increment              <= C_INC_RESET;
      end else if (good) begin
         if (cmd.cmd_type == CMD_SET_TIME) begin
            syntonised_nanosec_field_r <= {2'b00, cmd.cmd_nanosec};
            syntonised_sec_field_r     <= cmd.cmd_sec;
            syntonised_epoch_field_r   <= cmd.cmd_epoch;
         end
         if (cmd.cmd_type == CMD_SET_INC) rtc_increment <= cmd.cmd_increment;
      end
   end

   // CALC/NORM pipeline; SET_TIME clears the offset on the edge into APPLY.
   rtc_offset_norm u_norm (
      .clk     (rtc_clk),
      .rst_n   (rtc_reset),
      .calc_en (state == ST_CALC),
      .norm_en (state == ST_NORM),
      .clr     (state == ST_GAP),
      .sub     (cap_sub),
      .d_ns    (cap_ns),
      .d_sec   (cap_sec),
      .off_ns  (nanosec_offset),
      .off_sec (off_sec)
   );

endmodule

// File: tb/tb_rtc_adj_ctrl.sv
// Scoreboard bench for rtc_adj_ctrl: the driver pushes expected strobes and
// rejects, a negedge monitor pops and compares whenever the DUT presents one.
module tb_rtc_adj_ctrl;

   localparam logic [25:0] INC_RST = 26'h0800000;
   localparam int          SETTLE  = 3;
   localparam logic [95:0] NS      = 96'd1000000000;
   localparam logic [95:0] MODV    = (96'd1 << 48) * NS;

   typedef struct {
      int          cyc;
      bit          sw;
      logic [29:0] ns;
      logic [47:0] sec;
      logic [31:0] sns;
      logic [31:0] ssec;
      logic [15:0] sep;
   } exp_t;

   logic        rtc_clk = 1'b0;
   logic        rtc_reset = 1'b0;
   logic [31:0] syn_ns, syn_sec;
   logic [15:0] syn_ep;
   logic [29:0] nanosec_offset;
   logic [31:0] sec_offset;
   logic [15:0] epoch_offset;
   logic [25:0] rtc_increment;
   logic        gptp_vaild, gptp_sw;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   exp_t pq[$];
   int   eq[$];

   // reference model state
   logic [29:0] m_ns = '0;
   logic [47:0] m_sec = '0;
   logic [31:0] m_sns = '0, m_ssec = '0;
   logic [15:0] m_sep = '0;
   logic [25:0] m_inc = INC_RST;

   rtc_adj_ctrl_if cmd();

   rtc_adj_ctrl #(.C_INC_RESET(INC_RST), .C_SETTLE_CYCLES(SETTLE)) dut (
      .rtc_clk                    (rtc_clk),
      .rtc_reset                  (rtc_reset),
      .cmd                        (cmd),
      .syntonised_nanosec_field_r (syn_ns),
      .syntonised_sec_field_r     (syn_sec),
      .syntonised_epoch_field_r   (syn_ep),
      .nanosec_offset             (nanosec_offset),
      .sec_offset                 (sec_offset),
      .epoch_offset               (epoch_offset),
      .rtc_increment              (rtc_increment),
      .gptp_vaild                 (gptp_vaild),
      .gptp_sw                    (gptp_sw)
   );

   always #5 rtc_clk = ~rtc_clk;
   always @(posedge rtc_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Offset as one number of ns modulo 2^48 seconds.
   task automatic model_step(input bit sub, input logic [29:0] dns, input logic [47:0] ds);
      logic [95:0] t, d;
      t = {48'd0, m_sec} * NS + {66'd0, m_ns};
      d = {48'd0, ds} * NS + {66'd0, dns};
      if (sub) t = (t + MODV - d) % MODV;
      else     t = (t + d) % MODV;
      m_ns  = 30'(t % NS);
      m_sec = 48'(t / NS);
   endtask

   // Monitor: compare each strobe / reject against the scoreboard queues.
   always @(negedge rtc_clk) begin
      if (rtc_reset) begin
         exp_t e;
         int   ec;
         chk("increment", {38'd0, rtc_increment}, {38'd0, m_inc});
         if (!gptp_vaild) chk("sw_idle", {63'd0, gptp_sw}, 64'd1);
         if (gptp_vaild) begin
            if (pq.size() == 0) chk("unexpected_vaild", 64'd1, 64'd0);
            else begin
               e = pq.pop_front();
               chk("vaild_cycle", 64'(cyc), 64'(e.cyc));
               chk("vaild_sw", {63'd0, gptp_sw}, {63'd0, e.sw});
               chk("off_ns", {34'd0, nanosec_offset}, {34'd0, e.ns});
               chk("off_sec48", {16'd0, epoch_offset, sec_offset}, {16'd0, e.sec});
               chk("syn_ns", {32'd0, syn_ns}, {32'd0, e.sns});
               chk("syn_sec", {32'd0, syn_sec}, {32'd0, e.ssec});
               chk("syn_epoch", {48'd0, syn_ep}, {48'd0, e.sep});
            end
         end
         if (cmd.cmd_err) begin
            if (eq.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
            else begin
               ec = eq.pop_front();
               chk("err_cycle", 64'(cyc), 64'(ec));
            end
         end
      end
   end

   task automatic send(input logic [1:0] t, input logic sg, input logic [29:0] ns,
                       input logic [31:0] s, input logic [15:0] ep, input logic [25:0] inc);
      int   a, n;
      bit   bad;
      exp_t e;
      @(negedge rtc_clk);
      n = 0;
      while (!cmd.cmd_ready && n < 100) begin @(negedge rtc_clk); n++; end
      if (!cmd.cmd_ready) chk("ready_timeout", 64'd0, 64'd1);
      else begin
         cmd.cmd_type = t; cmd.cmd_sign = sg; cmd.cmd_nanosec = ns;
         cmd.cmd_sec = s; cmd.cmd_epoch = ep; cmd.cmd_increment = inc;
         cmd.cmd_valid = 1'b1;
         @(posedge rtc_clk);
         #1;
         a = cyc;
         cmd.cmd_valid = 1'b0;
         cmd.cmd_type = 2'($urandom); cmd.cmd_sign = 1'($urandom);
         cmd.cmd_nanosec = 30'($urandom); cmd.cmd_sec = $urandom;
         cmd.cmd_epoch = 16'($urandom); cmd.cmd_increment = 26'($urandom);
         bad = (t == 2'd3) || (t != 2'd2 && ns >= 30'd1000000000) || (t == 2'd2 && inc == '0);
         if (bad) begin
            eq.push_back(a);
            @(negedge rtc_clk);
            chk("ready_after_reject", {63'd0, cmd.cmd_ready}, 64'd1);
         end else if (t == 2'd2) begin
            m_inc = inc;
            @(negedge rtc_clk);
            chk("ready_low_inc", {63'd0, cmd.cmd_ready}, 64'd0);
            @(negedge rtc_clk);
            chk("ready_back_inc", {63'd0, cmd.cmd_ready}, 64'd1);
         end else begin
            if (t == 2'd0) begin
               m_sns = {2'b00, ns}; m_ssec = s; m_sep = ep;
               e = '{a, 1'b0, m_ns, m_sec, m_sns, m_ssec, m_sep};
               pq.push_back(e);
               m_ns = '0; m_sec = '0;
            end else model_step(sg, ns, {ep, s});
            e = '{a + 2, 1'b1, m_ns, m_sec, m_sns, m_ssec, m_sep};
            pq.push_back(e);
            while (cyc < a + 2 + SETTLE) @(negedge rtc_clk);
            chk("ready_low_settle", {63'd0, cmd.cmd_ready}, 64'd0);
            @(negedge rtc_clk);
            chk("ready_back", {63'd0, cmd.cmd_ready}, 64'd1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] rns;
      cmd.cmd_valid = 1'b0; cmd.cmd_type = '0; cmd.cmd_sign = 1'b0;
      cmd.cmd_nanosec = '0; cmd.cmd_sec = '0; cmd.cmd_epoch = '0; cmd.cmd_increment = '0;
      repeat (3) @(negedge rtc_clk);
      chk("rst_vaild", {63'd0, gptp_vaild}, 64'd0);
      chk("rst_sw", {63'd0, gptp_sw}, 64'd1);
      rtc_reset = 1'b1;
      repeat (10) @(negedge rtc_clk);
      chk("idle_ready", {63'd0, cmd.cmd_ready}, 64'd1);
      chk("idle_inc", {38'd0, rtc_increment}, 64'h0800000);
      chk("idle_off", {epoch_offset, sec_offset, 2'b00, nanosec_offset}, 64'd0);
      chk("idle_syn", {syn_ns, syn_sec}, 64'd0);

      // directed: carry, SET_TIME over nonzero offset, subtract wrap
      send(2'd1, 1'b0, 30'd600000000, 32'd0, 16'd0, 26'd0);
      send(2'd1, 1'b0, 30'd500000000, 32'd0, 16'd0, 26'd0);
      chk("carry_ns", {34'd0, nanosec_offset}, 64'd100000000);
      chk("carry_sec", {32'd0, sec_offset}, 64'd1);
      send(2'd0, 1'b0, 30'd5, 32'h10, 16'd2, 26'd0);
      send(2'd1, 1'b1, 30'd1, 32'd0, 16'd0, 26'd0);
      chk("wrap_ns", {34'd0, nanosec_offset}, 64'd999999999);
      chk("wrap_sec48", {16'd0, epoch_offset, sec_offset}, 64'hFFFFFFFFFFFF);

      // rejects
      send(2'd1, 1'b0, 30'd1000000000, 32'd3, 16'd0, 26'd0);
      send(2'd2, 1'b0, 30'd0, 32'd0, 16'd0, 26'd0);
      send(2'd3, 1'b0, 30'd10, 32'd0, 16'd0, 26'd5);
      send(2'd2, 1'b0, 30'd0, 32'd0, 16'd0, 26'h0123456);

      // randomized commands
      for (int i = 0; i < 40; i++) begin
         rns = ($urandom_range(0, 7) == 0) ? 30'(1000000000 + $urandom_range(0, 1000))
                                           : 30'($urandom_range(0, 999999999));
         send(2'($urandom_range(0, 3)), 1'($urandom), rns, $urandom, 16'($urandom),
              ($urandom_range(0, 7) == 0) ? 26'd0 : 26'($urandom));
      end

      // reset at T+2 of a STEP: nothing may complete afterwards
      @(negedge rtc_clk);
      cmd.cmd_type = 2'd1; cmd.cmd_sign = 1'b0; cmd.cmd_nanosec = 30'd7;
      cmd.cmd_sec = 32'd9; cmd.cmd_epoch = 16'd0; cmd.cmd_valid = 1'b1;
      @(posedge rtc_clk);
      #1;
      cmd.cmd_valid = 1'b0;
      @(negedge rtc_clk);
      @(negedge rtc_clk);
      #2;
      m_ns = '0; m_sec = '0; m_sns = '0; m_ssec = '0; m_sep = '0; m_inc = INC_RST;
      rtc_reset = 1'b0;
      #1;
      chk("mid_rst_vaild", {63'd0, gptp_vaild}, 64'd0);
      chk("mid_rst_sw", {63'd0, gptp_sw}, 64'd1);
      chk("mid_rst_ready", {63'd0, cmd.cmd_ready}, 64'd1);
      chk("mid_rst_err", {63'd0, cmd.cmd_err}, 64'd0);
      chk("mid_rst_inc", {38'd0, rtc_increment}, {38'd0, INC_RST});
      chk("mid_rst_off", {epoch_offset, sec_offset, 2'b00, nanosec_offset}, 64'd0);
      chk("mid_rst_syn", {syn_ns, syn_sec}, 64'd0);
      chk("mid_rst_syn_ep", {48'd0, syn_ep}, 64'd0);
      repeat (2) @(negedge rtc_clk);
      rtc_reset = 1'b1;
      repeat (12) @(negedge rtc_clk);
      chk("post_rst_off", {epoch_offset, sec_offset, 2'b00, nanosec_offset}, 64'd0);
      chk("pulse_queue_empty", 64'(pq.size()), 64'd0);
      chk("err_queue_empty", 64'(eq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
